// File: rtl/nbit_piso_pkg.sv
// Shared types and sizing helpers for the nbit_mwide_piso frame shifter.
package nbit_piso_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned DEF_M = 2;

  function automatic int unsigned idx_w(input int unsigned m);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/piso_word_cnt.sv
// Modulo-M word index counter with synchronous clear, restart and a registered
// terminal-count flag that is high while the index sits on the frame's last word.
module piso_word_cnt
  import nbit_piso_pkg::*;
#(
  parameter int unsigned M = DEF_M,
  parameter int unsigned W = idx_w(M)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic         en,
  output logic [W-1:0] idx,
  output logic         tc
);

  logic [W-1:0] idx_q, idx_d;
  logic         tc_q, tc_d;

  always_comb begin
    idx_d = idx_q;
    tc_d  = tc_q;
    if (clr) begin
      idx_d = '0;
      tc_d  = 1'b0;
    end else if (start) begin
      idx_d = '0;
      tc_d  = (M == 1);
    end else if (en) begin
      if (32'(idx_q) == M - 1) begin
        idx_d = '0;
        tc_d  = (M == 1);
      end else begin
        idx_d = idx_q + 1'b1;
        tc_d  = (32'(idx_q) + 32'd1 == M - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    tc_q  <= tc_d;
  end

  assign idx = idx_q;
  assign tc  = tc_q;

endmodule

// File: rtl/nbit_mwide_piso.sv
// Parallel-in / serial-out word shifter: loads an M-word frame, drains it one
// N-bit word per valid/ready handshake. Define NBIT_PISO_REVERSE_EN for word M-1 first.
module nbit_mwide_piso
  import nbit_piso_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned M = DEF_M
) (
  input  logic           Clk,
  input  logic           Clr,
  input  logic [M*N-1:0] PI,
  input  logic           LdValid,
  output logic           LdReady,
  output logic [N-1:0]   SO,
  output logic           SOValid,
  input  logic           SOReady,
  output logic           SOLast
);

  localparam int unsigned W = idx_w(M);

  state_e         state_q, state_d;
  logic [M*N-1:0] frame_q, frame_d;
  logic [N-1:0]   so_q, so_d;
  logic           so_valid_q, so_valid_d;
  logic [W-1:0]   idx;
  logic           so_last;
  logic           out_hs, ld_hs;
  logic           cnt_clr, cnt_start, cnt_en;

  // Emission position i maps to frame word i, or M-1-i in the reversed build.
  function automatic logic [N-1:0] pick(input logic [M*N-1:0] f, input int unsigned i);
    int unsigned k;
    logic [N-1:0] r;
`ifdef NBIT_PISO_REVERSE_EN
    k = M - 1 - i;
`else
    k = i;
`endif
    r = '0;
    for (int unsigned j = 0; j < M; j++)
      if (j == k) r = f[j*N +: N];
    return r;
  endfunction

  assign out_hs  = so_valid_q & SOReady;
  assign LdReady = (state_q == IDLE) | (out_hs & so_last);
  assign ld_hs   = LdValid & LdReady;

  // A reload on the last handshake restarts the counter instead of clearing it.
  assign cnt_start = ld_hs;
  assign cnt_en    = out_hs & ~so_last;
  assign cnt_clr   = Clr | (out_hs & so_last & ~ld_hs);

  piso_word_cnt #(.M(M), .W(W)) u_cnt (
    .clk   (Clk),
    .clr   (cnt_clr),
    .start (cnt_start),
    .en    (cnt_en),
    .idx   (idx),
    .tc    (so_last)
  );

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    so_d       = so_q;
    so_valid_d = so_valid_q;
    if (ld_hs) begin
      state_d    = SHIFT;
      frame_d    = PI;
      so_d       = pick(PI, 0);
      so_valid_d = 1'b1;
    end else if (state_q == SHIFT && out_hs) begin
      if (so_last) begin
        state_d    = IDLE;
        so_valid_d = 1'b0;
      end else begin
        so_d = pick(frame_q, 32'(idx) + 32'd1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      so_q       <= '0;
      so_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
    end
  end

  assign SO      = so_q;
  assign SOValid = so_valid_q;
  assign SOLast  = so_last;

endmodule
